// File: rtl/sd_arb_pkg.sv
// Shared state type, sector constants and round-robin helper for the SD sector arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } sd_arb_state_t;

    localparam int SD_SECTOR_BYTES = 512;
    localparam int SD_CNT_W        = 10;
    localparam logic [SD_CNT_W-1:0] SD_CNT_FULL = SD_CNT_W'(SD_SECTOR_BYTES);

    // The pointer's requester wins when it is asking, otherwise the other one.
    function automatic logic rr_pick(input logic [1:0] cand, input logic rr);
        return cand[rr] ? rr : ~rr;
    endfunction

endpackage

// File: rtl/sd_sync_edge.sv
// Two-flop synchronizer with a third edge register; rise/fall pulses last one clk cycle.
module sd_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/sd_sector_arb.sv
// Round-robin two-requester SD sector controller bridging user_io to requester sector buffers.
// Optional REQ-phase ack timeout is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arb
    import sd_arb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_dout,
    output logic [1:0]  buf_we,
    input  logic [7:0]  buf_din0,
    input  logic [7:0]  buf_din1,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_strobe,
    input  logic        sd_din_strobe,
    output logic [7:0]  sd_din
);

    sd_arb_state_t r_state;
    sd_arb_state_t w_next;

    logic                r_gnt;
    logic                r_dir_rd;
    logic                r_rr;
    logic [SD_CNT_W-1:0] r_cnt;
    logic                r_overrun;
    logic                r_tmo_hit;
    logic [31:0]         r_sd_lba;
    logic                r_sd_rd;
    logic                r_sd_wr;
    logic [7:0]          r_sd_din;
    logic [8:0]          r_buf_addr;
    logic [7:0]          r_buf_dout;
    logic [1:0]          r_buf_we;
    logic [1:0]          r_done;
    logic [1:0]          r_err;

    logic       w_ack_rise;
    logic       w_ack_fall;
    logic       w_dout_rise;
    logic       w_dout_fall_unused;
    logic       w_din_rise;
    logic       w_din_fall_unused;
    logic [1:0] w_cand;
    logic       w_pick;
    logic       w_grant;
    logic       w_timeout;
    logic [7:0] w_buf_din;

    sd_sync_edge u_sync_ack (
        .clk     (clk),
        .reset   (reset),
        .i_async (sd_ack),
        .o_rise  (w_ack_rise),
        .o_fall  (w_ack_fall)
    );

    sd_sync_edge u_sync_dout (
        .clk     (clk),
        .reset   (reset),
        .i_async (sd_dout_strobe),
        .o_rise  (w_dout_rise),
        .o_fall  (w_dout_fall_unused)
    );

    sd_sync_edge u_sync_din (
        .clk     (clk),
        .reset   (reset),
        .i_async (sd_din_strobe),
        .o_rise  (w_din_rise),
        .o_fall  (w_din_fall_unused)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] r_tmo_cnt;

    // Counts cycles spent waiting for ack; cleared whenever we leave REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_REQ) begin
            r_tmo_cnt <= r_tmo_cnt + 24'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_REQ) && (r_tmo_cnt == TIMEOUT - 24'd1);
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT;
`endif

    assign w_cand    = req_rd | req_wr;
    assign w_pick    = rr_pick(w_cand, r_rr);
    assign w_buf_din = r_gnt ? buf_din1 : buf_din0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_grant = 1'b1;
                    w_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_rise) begin
                    w_next = ST_XFER;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_XFER: begin
                if (w_ack_fall) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_dir_rd   <= 1'b0;
            r_rr       <= 1'b0;
            r_cnt      <= '0;
            r_overrun  <= 1'b0;
            r_tmo_hit  <= 1'b0;
            r_sd_lba   <= '0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_sd_din   <= '0;
            r_buf_addr <= '0;
            r_buf_dout <= '0;
            r_buf_we   <= '0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            r_buf_we <= '0;
            r_done   <= '0;
            r_err    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_gnt     <= w_pick;
                        r_dir_rd  <= req_rd[w_pick];
                        r_sd_lba  <= w_pick ? req_lba1 : req_lba0;
                        r_sd_rd   <= req_rd[w_pick];
                        r_sd_wr   <= ~req_rd[w_pick];
                        r_cnt     <= '0;
                        r_overrun <= 1'b0;
                        r_tmo_hit <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                    end else if (w_timeout) begin
                        r_sd_rd   <= 1'b0;
                        r_sd_wr   <= 1'b0;
                        r_tmo_hit <= 1'b1;
                    end
                end
                ST_XFER: begin
                    // Bytes beyond a full sector are dropped; only reads flag them.
                    if (r_dir_rd && w_dout_rise) begin
                        if (r_cnt < SD_CNT_FULL) begin
                            r_buf_dout <= sd_dout;
                            r_buf_addr <= r_cnt[8:0];
                            r_buf_we   <= r_gnt ? 2'b10 : 2'b01;
                            r_cnt      <= r_cnt + 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (!r_dir_rd && w_din_rise && (r_cnt < SD_CNT_FULL)) begin
                        r_sd_din <= w_buf_din;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= r_gnt ? 2'b10 : 2'b01;
                    if ((r_dir_rd && (r_cnt != SD_CNT_FULL)) || r_overrun || r_tmo_hit) begin
                        r_err <= r_gnt ? 2'b10 : 2'b01;
                    end
                    r_rr <= ~r_gnt;
                end
                default: begin
                end
            endcase
        end
    end

    // Write direction presents cnt straight to the buffer so its read data is ready by the next strobe.
    assign buf_addr = ((r_state == ST_XFER) && !r_dir_rd) ? r_cnt[8:0] : r_buf_addr;
    assign buf_dout = r_buf_dout;
    assign buf_we   = r_buf_we;
    assign sd_lba   = r_sd_lba;
    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;
    assign sd_din   = r_sd_din;
    assign done     = r_done;
    assign err      = r_err;
    assign busy     = (r_state != ST_IDLE);

endmodule
